// File: rtl/hazard_sched_unit.sv
// Execute-stage hazard controller: operand forwarding, load-use bubble,
// redirect flushes and start/done sequencing of the shared multi-cycle unit.
module hazard_sched_unit #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_rs1_d,
  input  logic [4:0] i_rs2_d,
  input  logic [4:0] i_rs1_e_h,
  input  logic [4:0] i_rs2_e_h,
  input  logic [4:0] i_rd_e,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_write_m,
  input  logic       i_reg_write_w,
  input  logic [1:0] i_result_src_e,
  input  logic       i_pc_src_e,
  input  logic       i_multi_cycle_e,
  input  logic       i_mdu_done,
  output logic [1:0] o_forward_ae,
  output logic [1:0] o_forward_be,
  output logic       o_stall_f,
  output logic       o_stall_d,
  output logic       o_stall_e,
  output logic       o_flush_d,
  output logic       o_flush_e,
  output logic       o_flush_m,
  output logic       o_mdu_start,
  output logic       o_mdu_abort,
  output logic       o_mc_error
);

  // state   | meaning
  // RUN     | normal issue; forwarding, load-use and redirect handling
  // MC_WAIT | front end held while the MDU works; waits for done/redirect/timeout
  typedef enum logic {ST_RUN, ST_MC_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mc_error;

  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_lw_stall;
  logic       w_stall, w_flush_d, w_flush_e, w_flush_m;
  logic       w_start, w_abort, w_set_err;

  always_comb begin
    w_fwd_a = 2'b00;
    if (i_reg_write_m && i_rd_m != 5'd0 && i_rd_m == i_rs1_e_h)      w_fwd_a = 2'b10;
    else if (i_reg_write_w && i_rd_w != 5'd0 && i_rd_w == i_rs1_e_h) w_fwd_a = 2'b01;
    w_fwd_b = 2'b00;
    if (i_reg_write_m && i_rd_m != 5'd0 && i_rd_m == i_rs2_e_h)      w_fwd_b = 2'b10;
    else if (i_reg_write_w && i_rd_w != 5'd0 && i_rd_w == i_rs2_e_h) w_fwd_b = 2'b01;
  end

  assign w_lw_stall = (i_result_src_e == 2'b01) && (i_rd_e != 5'd0) &&
                      ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

  // Load-use stall leaves E running (stall_e stays 0); w_stall covers F/D/E together.
  logic w_stall_fd_only;

  always_comb begin
    w_state_nxt     = r_state;
    w_stall         = 1'b0;
    w_stall_fd_only = 1'b0;
    w_flush_d       = 1'b0;
    w_flush_e       = 1'b0;
    w_flush_m       = 1'b0;
    w_start         = 1'b0;
    w_abort         = 1'b0;
    w_set_err       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_pc_src_e) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
          w_flush_m = 1'b1;
        end else if (i_multi_cycle_e) begin
          w_stall     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = ST_MC_WAIT;
        end else if (w_lw_stall) begin
          w_stall_fd_only = 1'b1;
          w_flush_e       = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        if (i_pc_src_e) begin
          w_flush_d   = 1'b1;
          w_flush_e   = 1'b1;
          w_flush_m   = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (i_mdu_done) begin
          w_state_nxt = ST_RUN;
        end else if (r_cnt == CNT_LAST) begin
          w_stall     = 1'b1;
          w_flush_e   = 1'b1;
          w_abort     = 1'b1;
          w_set_err   = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_mc_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start)                    r_cnt <= '0;
      else if (r_state == ST_MC_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      if (w_set_err) r_mc_error <= 1'b1;
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign o_forward_ae = i_rst_n ? w_fwd_a : 2'b00;
  assign o_forward_be = i_rst_n ? w_fwd_b : 2'b00;
  assign o_stall_f    = i_rst_n & (w_stall | w_stall_fd_only);
  assign o_stall_d    = i_rst_n & (w_stall | w_stall_fd_only);
  assign o_stall_e    = i_rst_n & w_stall;
  assign o_flush_d    = i_rst_n & w_flush_d;
  assign o_flush_e    = i_rst_n & w_flush_e;
  assign o_flush_m    = i_rst_n & w_flush_m;
  assign o_mdu_start  = i_rst_n & w_start;
  assign o_mdu_abort  = i_rst_n & w_abort;
  assign o_mc_error   = i_rst_n & r_mc_error;

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Bench for hazard_sched_unit: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the hazard rules.
module tb_hazard_sched_unit;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       rw_m, rw_w, pcsrc, mc, done;
  logic [1:0] rsrc;
  logic [1:0] fa, fb;
  logic       st_f, st_d, st_e, fl_d, fl_e, fl_m, start, abort, err;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: -1 = idle, else number of wait cycles already spent
  int m_wait = -1;
  bit m_err  = 1'b0;

  always #5 clk = ~clk;

  hazard_sched_unit #(.MC_TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e_h(rs1_e), .i_rs2_e_h(rs2_e),
    .i_rd_e(rd_e), .i_rd_m(rd_m), .i_rd_w(rd_w),
    .i_reg_write_m(rw_m), .i_reg_write_w(rw_w), .i_result_src_e(rsrc),
    .i_pc_src_e(pcsrc), .i_multi_cycle_e(mc), .i_mdu_done(done),
    .o_forward_ae(fa), .o_forward_be(fb),
    .o_stall_f(st_f), .o_stall_d(st_d), .o_stall_e(st_e),
    .o_flush_d(fl_d), .o_flush_e(fl_e), .o_flush_m(fl_m),
    .o_mdu_start(start), .o_mdu_abort(abort), .o_mc_error(err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (rw_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (rw_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {rw_m, rw_w, pcsrc, mc, done} = '0;
    rsrc = 2'b00;
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step(input string tag);
    logic [7:0] e_ctl;   // {stall F,D,E, flush D,E,M, start, abort}
    int  nxt;
    bit  lw;
    e_ctl = '0;
    nxt   = m_wait;
    lw    = (rsrc == 2'b01) && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    if (m_wait < 0) begin
      if (pcsrc)   e_ctl = 8'b000_111_0_0;
      else if (mc) begin e_ctl = 8'b111_000_1_0; nxt = 0; end
      else if (lw) e_ctl = 8'b110_010_0_0;
    end else begin
      nxt = -1;
      if (pcsrc)                       e_ctl = 8'b000_111_0_1;
      else if (done)                   e_ctl = 8'b000_000_0_0;
      else if (m_wait + 1 == TIMEOUT)  e_ctl = 8'b111_010_0_1;
      else begin e_ctl = 8'b111_000_0_0; nxt = m_wait + 1; end
    end
    #1;
    chk({tag, ".fwd"}, 16'({fa, fb}), 16'({fwd_ref(rs1_e), fwd_ref(rs2_e)}));
    chk({tag, ".ctl"}, 16'({st_f, st_d, st_e, fl_d, fl_e, fl_m, start, abort}), 16'(e_ctl));
    chk({tag, ".err"}, 16'(err), 16'(m_err));
    @(posedge clk);
    if (m_wait >= 0 && !pcsrc && !done && m_wait + 1 == TIMEOUT) m_err = 1'b1;
    m_wait = nxt;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst.fwd", 16'({fa, fb}), 16'h0);
    chk("rst.ctl", 16'({st_f, st_d, st_e, fl_d, fl_e, fl_m, start, abort, err}), 16'h0);
    m_wait = -1;
    m_err  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    mc = 1'b1; rw_m = 1'b1; rd_m = 5'd3; rs1_e = 5'd3;
    do_reset();
    clear_inputs();

    // forwarding: M wins over W, W used when RD_M is x0
    rd_m = 5; rw_m = 1; rd_w = 5; rw_w = 1; rs1_e = 5;
    #1 chk("fwd.m_prio", 16'(fa), 16'h2);
    step("t1a");
    rd_m = 0;
    #1 chk("fwd.w_only", 16'(fa), 16'h1);
    step("t1b");
    clear_inputs();

    // load-use bubble, and no stall when RD_E is x0
    rsrc = 2'b01; rd_e = 7; rs2_d = 7;
    #1 chk("lw.stall", 16'({st_f, st_d, st_e, fl_e}), 16'b1101);
    step("t2a");
    rd_e = 0;
    step("t2b");
    clear_inputs();

    // multi-cycle with done on the fourth wait cycle
    mc = 1; step("t3.start"); mc = 0;
    for (int i = 0; i < 3; i++) step("t3.wait");
    done = 1;
    #1 chk("mc.done_nostall", 16'({st_f, st_d, st_e}), 16'h0);
    step("t3.done"); done = 0;
    step("t3.run");

    // redirect and done together while waiting
    mc = 1; step("t4.start"); mc = 0;
    step("t4.wait");
    pcsrc = 1; done = 1;
    #1 chk("mc.redirect", 16'({fl_d, fl_e, fl_m, abort}), 16'hF);
    step("t4.redir");
    clear_inputs();
    step("t4.run");

    // timeout, sticky error
    mc = 1; step("t5.start"); mc = 0;
    for (int i = 0; i < TIMEOUT; i++) step("t5.wait");
    #1 chk("mc.err_sticky", 16'(err), 16'h1);
    for (int i = 0; i < 3; i++) step("t5.after");

    // reset in the middle of a wait, then a clean restart
    mc = 1; step("t6.start"); mc = 0;
    step("t6.wait");
    do_reset();
    #1 chk("rst.err_clear", 16'(err), 16'h0);
    @(negedge clk);
    mc = 1; step("t6.restart"); mc = 0;
    done = 1; step("t6.done"); done = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      rw_m  = 1'($urandom_range(0, 1)); rw_w = 1'($urandom_range(0, 1));
      rsrc  = 2'($urandom_range(0, 3));
      pcsrc = ($urandom_range(0, 11) == 0);
      mc    = ($urandom_range(0, 5) == 0);
      done  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
